// File: rtl/lane_bus_unpacker_pkg.sv
// rtl/lane_bus_unpacker_pkg.sv - shared lane-bus constants, types and lane slicing helper
package lane_bus_unpacker_pkg;

    localparam int LEN_CODED_BLOCK = 66;
    localparam int N_LANES         = 20;
    localparam int NB_DATA_BUS     = N_LANES * LEN_CODED_BLOCK;
    localparam int LANE_W          = $clog2(N_LANES);

    typedef logic [LEN_CODED_BLOCK-1:0] block_t;
    typedef logic [NB_DATA_BUS-1:0]     bus_word_t;
    typedef logic [LANE_W-1:0]          lane_idx_t;

    // Lane 0 occupies the most significant block of the bus word; the packer
    // uses the same convention, so both sides agree on block order.
    function automatic block_t lane_slice(input bus_word_t bus, input int unsigned idx);
        int unsigned shift;
        shift = (N_LANES - 1 - idx) * LEN_CODED_BLOCK;
        return block_t'(bus >> shift);
    endfunction

endpackage

// File: rtl/lane_bus_unpacker_if.sv
// rtl/lane_bus_unpacker_if.sv - lane bus input and block stream output bundle
interface lane_bus_unpacker_if;
    import lane_bus_unpacker_pkg::*;

    logic      i_bus_valid;
    bus_word_t i_bus_data;
    logic      o_bus_ready;
    logic      i_valid;
    logic      o_valid;
    block_t    o_data;
    lane_idx_t o_lane_idx;
    logic      o_underflow;
    logic      o_empty;

    modport master (
        output i_bus_valid, i_bus_data, i_valid,
        input  o_bus_ready, o_valid, o_data, o_lane_idx, o_underflow, o_empty
    );

    modport slave (
        input  i_bus_valid, i_bus_data, i_valid,
        output o_bus_ready, o_valid, o_data, o_lane_idx, o_underflow, o_empty
    );

endinterface

// File: rtl/lane_bus_unpacker_fifo.sv
// rtl/lane_bus_unpacker_fifo.sv - small bus-word FIFO with ready/empty and explicit pointer wrap
module lane_bus_unpacker_fifo
    import lane_bus_unpacker_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clock,
    input  logic      i_reset,
    input  logic      i_enable,
    input  logic      i_push_valid,
    input  bus_word_t i_push_data,
    output logic      o_push_ready,
    input  logic      i_pop,
    output bus_word_t o_rd_data,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    bus_word_t        mem_q [DEPTH];

    logic push;
    logic pop;

    // Depth need not be a power of two, so pointers wrap on an explicit compare.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // Ready comes from the registered count only; a same-cycle pop never raises it.
    assign o_push_ready = i_enable && (count_q < CNT_W'(DEPTH));
    assign o_empty      = (count_q == '0);
    assign push         = i_push_valid && o_push_ready;
    assign pop          = i_pop && i_enable && !o_empty;
    assign o_rd_data    = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards buffered words by clearing occupancy.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/lane_bus_unpacker.sv
// rtl/lane_bus_unpacker.sv - unpacks buffered lane-bus words into a serial coded-block stream
module lane_bus_unpacker
    import lane_bus_unpacker_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    lane_bus_unpacker_if.slave bus
);

    bus_word_t rd_word;
    logic      fifo_empty;
    logic      strobe;
    logic      word_pop;
    logic      last_lane;

    lane_idx_t lane_cnt_q,    lane_cnt_d;
    lane_idx_t o_lane_idx_q,  o_lane_idx_d;
    block_t    o_data_q,      o_data_d;
    logic      o_valid_q,     o_valid_d;
    logic      o_underflow_q, o_underflow_d;

    lane_bus_unpacker_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_push_valid (bus.i_bus_valid),
        .i_push_data  (bus.i_bus_data),
        .o_push_ready (bus.o_bus_ready),
        .i_pop        (word_pop),
        .o_rd_data    (rd_word),
        .o_empty      (fifo_empty)
    );

    assign strobe    = i_enable && bus.i_valid;
    assign last_lane = (lane_cnt_q == LANE_W'(N_LANES - 1));
    // The head word leaves the FIFO only once its last lane has been emitted.
    assign word_pop  = strobe && !fifo_empty && last_lane;

    // Per-strobe block selection, lane advance and underflow detection.
    always_comb begin
        lane_cnt_d    = lane_cnt_q;
        o_lane_idx_d  = o_lane_idx_q;
        o_data_d      = o_data_q;
        o_valid_d     = 1'b0;
        o_underflow_d = 1'b0;
        if (strobe) begin
            if (!fifo_empty) begin
                o_data_d     = lane_slice(rd_word, 32'(lane_cnt_q));
                o_lane_idx_d = lane_cnt_q;
                o_valid_d    = 1'b1;
                if (last_lane) begin
                    lane_cnt_d = '0;
                end else begin
                    lane_cnt_d = lane_cnt_q + LANE_W'(1);
                end
            end else begin
                o_underflow_d = 1'b1;
            end
        end
    end

    // Output and lane counter registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            lane_cnt_q    <= '0;
            o_lane_idx_q  <= '0;
            o_data_q      <= '0;
            o_valid_q     <= 1'b0;
            o_underflow_q <= 1'b0;
        end else begin
            lane_cnt_q    <= lane_cnt_d;
            o_lane_idx_q  <= o_lane_idx_d;
            o_data_q      <= o_data_d;
            o_valid_q     <= o_valid_d;
            o_underflow_q <= o_underflow_d;
        end
    end

    assign bus.o_valid     = o_valid_q;
    assign bus.o_data      = o_data_q;
    assign bus.o_lane_idx  = o_lane_idx_q;
    assign bus.o_underflow = o_underflow_q;
    assign bus.o_empty     = fifo_empty;

endmodule

// File: doc/lane_bus_unpacker.md
# lane_bus_unpacker

Receive-side counterpart of the 1-to-N lane packer. It accepts 20-lane parallel bus words (N_LANES × 66-bit blocks) through a ready/valid handshake and buffers them in a small word FIFO. It then emits them as a single 66-bit block stream, one block per output-rate `i_valid` strobe. It sits between the parallel lane bus and the serial block-processing path, absorbing the phase difference between the bus-word cadence and the block cadence.

## Interface
- `LEN_CODED_BLOCK`, default 66: bits per coded block.
- `N_LANES`, default 20: blocks per bus word.
- `NB_DATA_BUS`, default `N_LANES*LEN_CODED_BLOCK`: bus width.
- `FIFO_DEPTH`, default 2: bus words buffered; must be ≥2, not required to be a power of 2.
- `i_clock`  in  1: single clock, all logic rising-edge.
- `i_reset`  in  1: asynchronous, active-low reset.
- `i_enable`  in  1: global enable; low freezes all state.
- `i_bus_valid`  in  1: `i_bus_data` holds a word.
- `i_bus_data`  in  `NB_DATA_BUS`: lane 0 at `[NB_DATA_BUS-1 -: LEN_CODED_BLOCK]`, lane k at `[NB_DATA_BUS-1-k*LEN_CODED_BLOCK -: LEN_CODED_BLOCK]`.
- `o_bus_ready`  out  1: a word is accepted on an edge where `i_bus_valid && o_bus_ready`.
- `i_valid`  in  1: output-rate strobe; requests one block.
- `o_valid`  out  1: `o_data` updated this cycle.
- `o_data`  out  `LEN_CODED_BLOCK`: current block.
- `o_lane_idx`  out  `$clog2(N_LANES)`: lane index of `o_data`.
- `o_underflow`  out  1: one-cycle pulse when `i_valid` arrives with the FIFO empty.
- `o_empty`  out  1: FIFO holds no word.

## Operation
- State:
  - `wr_ptr`, `rd_ptr`: 0..FIFO_DEPTH-1, each wraps explicitly to 0.
  - `count`: 0..FIFO_DEPTH, width `$clog2(FIFO_DEPTH+1)`.
  - `lane_cnt`: 0..N_LANES-1.
- Push happens when `i_enable && i_bus_valid && o_bus_ready`:
  - Write the word at `wr_ptr`, then advance `wr_ptr`.
- Pop request, when `i_enable && i_valid && count!=0`:
  - `o_data <= slice(rd_ptr, lane_cnt)`.
  - `o_lane_idx <= lane_cnt`.
  - `o_valid <= 1`.
  - If `lane_cnt==N_LANES-1`: `lane_cnt <= 0`, advance `rd_ptr` (word popped). Otherwise `lane_cnt++`.
- Underflow, when `i_enable && i_valid && count==0`:
  - `o_valid <= 0`, `o_underflow <= 1`.
  - `o_data` and `lane_cnt` hold.
- When there is no `i_valid`: `o_valid <= 0`, `o_underflow <= 0`, `o_data` holds.
- Count update:
  - `+1` on push only.
  - `−1` on word pop only.
  - Unchanged on simultaneous push and word pop.
- `o_bus_ready = i_enable && (count < FIFO_DEPTH)`. Combinational from registered `count`. A pop in the same cycle does not raise ready.
- `i_bus_valid` while ready is low: the word is ignored, with no error flag. The sender must hold it.
- `o_empty = (count==0)`.
- `i_enable` low: all registers hold, except `o_valid` and `o_underflow`, which clear to 0. `o_bus_ready` is 0.
- Reset (async assert, any time, including mid-word):
  - All pointers, count and `lane_cnt` go to 0.
  - `o_data` goes to 0; `o_valid`, `o_underflow` and `o_lane_idx` go to 0.
  - Buffered words are discarded.
  - `o_bus_ready` follows `i_enable`.

## Timing
- Push at edge k: `count` and `o_empty` update after edge k.
- The earliest block comes from an `i_valid` sampled at edge k+1 and is visible after that edge.
- Output latency is one edge from `i_valid` to `o_valid`/`o_data`.
- A full word drains in N_LANES `i_valid` strobes. Back-to-back strobes give N_LANES consecutive valid cycles.
- With `FIFO_DEPTH=2` and one word per N_LANES strobes, the stream is gap-free with no underflow.

## Structure
- Shared package (`pcs_pkg`) holds:
  - `LEN_CODED_BLOCK` and `N_LANES` defaults.
  - The lane-0-at-MSB slice convention as a function `lane_slice(bus, idx)`.
  - Shared with the 1-to-N packer.
- One sub-module is natural: `bus_word_fifo`, covering storage, pointers, count, ready and empty. The top level holds the lane counter, output registers and underflow logic.

## Test plan
- Reset, `i_enable=1`, push one word with lane k = `{2'b01, 64'(k)}`, then 20 back-to-back `i_valid`:
  - `o_data` sequence is lane 0..19.
  - `o_lane_idx` counts 0..19.
  - `o_empty=1` after the 20th strobe.
- Push two words, then hold `i_bus_valid` with a third:
  - `o_bus_ready=0` with `count=2`.
  - The third word is accepted one edge after the 20th pop of word 0.
  - Output shows word0, word1, word2 in order.
- `i_valid` with FIFO empty:
  - `o_underflow` pulses for exactly 1 cycle, `o_valid=0`.
  - `o_data` is unchanged.
  - `lane_cnt` is still 0 when the next word arrives.
- Drop `i_enable` after 7 pops for 5 cycles:
  - `o_valid=0`, `o_bus_ready=0`.
  - On re-enable, the next block is lane 7 of the same word.
- Assert `i_reset=0` after lane 12 is emitted, with 2 words buffered:
  - All outputs go to 0 immediately, `o_empty=1`.
  - After release, a new word drains from lane 0.
- Stimulus: one bus word per 20 strobes from two valid generators, `COUNT_SCALE=2`, limits 1 and 20, run for 1000 words. Required response:
  - No underflow.
  - Serial output equals the original block stream fed to the 1-to-N packer.
